pow_pipe: RTL and testbench
===========================

// Module: pow_pipe
// PURPOSE
//  Pipelined integer power unit: y = a^EXP mod 2^OUT_WIDTH, one operand accepted per cycle.
//  Generalises the fixed-width pow block to a parametrised width, exponent and output width.
//  Adds valid/ready flow control on both sides. Sits between operand generator and result
//  checker in lesson datapaths.
// PARAMETERS
//  WIDTH      32  operand width in bits
//  EXP        4   exponent, integer >= 1; also pipeline depth
//  OUT_WIDTH  32  result width; products are truncated to OUT_WIDTH LSBs at every stage
// PORTS
//  clk        in   1          clock; all logic on posedge
//  rst        in   1          synchronous, active-high reset
//  in_valid   in   1          operand a is valid
//  in_ready   out  1          unit accepts operand this cycle
//  a          in   WIDTH      base operand, unsigned
//  out_valid  out  1          result y is valid
//  out_ready  in   1          consumer accepts y this cycle
//  y          out  OUT_WIDTH  a^EXP, truncated
//  out_ovf    out  1          present only with POW_PIPE_OVF_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (sampled on posedge clk, rst=1): all stage valid bits = 0, out_valid = 0, y = 0,
//    out_ovf = 0. rst overrides any handshake in the same cycle.
//  - Pipeline: EXP register stages S1..S_EXP. Each Sk holds {vld_k, base_k, acc_k}.
//    S1 <= {in_valid, a, a} (a zero-extended to OUT_WIDTH).
//    Sk <= {vld_k-1, base_k-1, (acc_k-1 * base_k-1)[OUT_WIDTH-1:0]} for k = 2..EXP.
//    y = acc_EXP, out_valid = vld_EXP. EXP=1: y = a zero-extended/truncated, latency 1.
//  - Latency: exactly EXP cycles from accept (in_valid & in_ready) to out_valid, absent stall.
//  - Flow control: adv = ~out_valid | out_ready; in_ready = adv (combinational).
//    adv=1: all stages shift by one. adv=0: every stage holds; y and out_valid stay stable.
//  - Bubbles are not collapsed: an empty stage still occupies its slot.
//  - Throughput: 1 result/cycle while out_ready = 1.
//  - Data on stages with vld=0 is don't-care, but y must not change while out_valid=1 & ~out_ready.
//  - Simultaneous accept and emit in one cycle is legal; order is strictly FIFO.
//  - Reset mid-operation discards all in-flight operands; no result is emitted for them.
//  - Arithmetic: unsigned; a=0 gives 0; a=1 gives 1; wrap-around is modulo 2^OUT_WIDTH.
// CONFIGURATION
//  POW_PIPE_OVF_EN defined:
//    - Each stage also carries a sticky ovf_k.
//    - ovf_1 = 1 if WIDTH > OUT_WIDTH and a has any bit set above OUT_WIDTH-1.
//    - ovf_k = ovf_k-1 | (full product of acc_k-1 * base_k-1 is >= 2^OUT_WIDTH).
//    - out_ovf = ovf_EXP; it is qualified by out_valid, reset to 0, and held on stall like y.
//  POW_PIPE_OVF_EN undefined:
//    - No out_ovf port and no overflow logic. Truncation is silent.
// TESTING (WIDTH=32, EXP=4, OUT_WIDTH=32 unless stated)
//  1. Basic: out_ready=1; a=3 accepted at cycle 0 -> out_valid=1, y=81 at cycle 4.
//  2. Streaming: a=0,1,2,25 on consecutive cycles with out_ready=1 -> y=0,1,16,390625
//     on 4 consecutive cycles. in_ready=1 throughout.
//  3. Backpressure: hold out_ready=0 for 3 cycles while out_valid=1 -> y and out_valid
//     stable, in_ready=0. After release, no loss or duplication of results.
//  4. Wrap/ovf: a=256 -> y=0 (2^32 mod 2^32); with POW_PIPE_OVF_EN, out_ovf=1.
//     a=255 -> y=4228250625, out_ovf=0.
//  5. Reset mid-flight: accept a=2,3,4, assert rst 1 cycle at cycle 2 -> out_valid stays 0
//     until the next accepted operand completes.
//  6. EXP=1, OUT_WIDTH=8: a=300 -> y=44 after 1 cycle; with POW_PIPE_OVF_EN, out_ovf=1.

Source files
------------

// File: rtl/pow_pipe.sv
// pow_pipe: pipelined y = a^EXP mod 2^OUT_WIDTH with valid/ready on both sides.
// Optional sticky overflow flag on out_ovf when POW_PIPE_OVF_EN is defined.
module pow_pipe #(
    parameter int WIDTH     = 32,
    parameter int EXP       = 4,
    parameter int OUT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] y
`ifdef POW_PIPE_OVF_EN
    ,
    output logic                 out_ovf
`endif
);

`ifdef POW_PIPE_OVF_EN
    // Full-width products so the bits above OUT_WIDTH reveal overflow.
    localparam int PW = OUT_WIDTH + WIDTH;
`else
    // Only the retained low bits of each product are ever needed.
    localparam int PW = OUT_WIDTH;
`endif

    logic                 adv;
    logic [EXP-1:0]       vld_q;
    logic [OUT_WIDTH-1:0] acc_q [EXP];

    // The whole pipe moves as one unit: shift unless the output is held.
    assign adv       = ~vld_q[EXP-1] | out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_q[EXP-1];
    assign y         = acc_q[EXP-1];

`ifdef POW_PIPE_OVF_EN
    logic [EXP-1:0] ovf_q;
    logic           ovf1;

    // Operand bits that do not fit in the result width already overflow.
    assign ovf1    = ((PW'(a) >> OUT_WIDTH) != '0);
    assign out_ovf = ovf_q[EXP-1];
`endif

    generate
        if (EXP > 1) begin : g_deep
            logic [WIDTH-1:0] base_q [EXP-1];
            logic [PW-1:0]    prod   [EXP-1];

            // One multiply per stage boundary: acc_k * base_k.
            always_comb begin
                for (int k = 0; k < EXP - 1; k++) begin
                    prod[k] = PW'(acc_q[k]) * PW'(base_q[k]);
                end
            end

            // Stage registers: shift on adv, hold otherwise.
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_q <= '0;
                    for (int k = 0; k < EXP; k++) begin
                        acc_q[k] <= '0;
                    end
                    for (int k = 0; k < EXP - 1; k++) begin
                        base_q[k] <= '0;
                    end
`ifdef POW_PIPE_OVF_EN
                    ovf_q <= '0;
`endif
                end else if (adv) begin
                    vld_q     <= {vld_q[EXP-2:0], in_valid};
                    acc_q[0]  <= OUT_WIDTH'(a);
                    base_q[0] <= a;
                    for (int k = 1; k < EXP; k++) begin
                        acc_q[k] <= prod[k-1][OUT_WIDTH-1:0];
                    end
                    for (int k = 1; k < EXP - 1; k++) begin
                        base_q[k] <= base_q[k-1];
                    end
`ifdef POW_PIPE_OVF_EN
                    ovf_q[0] <= ovf1;
                    for (int k = 1; k < EXP; k++) begin
                        ovf_q[k] <= ovf_q[k-1]
                                  | (prod[k-1][PW-1:OUT_WIDTH] != '0);
                    end
`endif
                end
            end
        end else begin : g_single
            // Single stage: the result is the operand itself, resized.
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_q    <= '0;
                    acc_q[0] <= '0;
`ifdef POW_PIPE_OVF_EN
                    ovf_q    <= '0;
`endif
                end else if (adv) begin
                    vld_q[0] <= in_valid;
                    acc_q[0] <= OUT_WIDTH'(a);
`ifdef POW_PIPE_OVF_EN
                    ovf_q[0] <= ovf1;
`endif
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_pow_pipe.sv
// tb_pow_pipe: directed vectors for pow_pipe (EXP=4 main instance,
// EXP=1/OUT_WIDTH=8 secondary instance).
module tb_pow_pipe;

    localparam int EXP = 4;
    localparam int N   = 13;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] y;

    logic        in_valid1 = 1'b0;
    logic        in_ready1;
    logic [31:0] a1 = '0;
    logic        out_valid1;
    logic        out_ready1 = 1'b1;
    logic [7:0]  y1;

`ifdef POW_PIPE_OVF_EN
    logic        out_ovf;
    logic        out_ovf1;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] y;
        logic        ovf;
    } vec_t;

    vec_t tbl [N];

    always #5 clk = ~clk;

    pow_pipe #(.WIDTH(32), .EXP(EXP), .OUT_WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y)
`ifdef POW_PIPE_OVF_EN
        ,
        .out_ovf   (out_ovf)
`endif
    );

    pow_pipe #(.WIDTH(32), .EXP(1), .OUT_WIDTH(8)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .y         (y1)
`ifdef POW_PIPE_OVF_EN
        ,
        .out_ovf   (out_ovf1)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_valid1 = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{32'd3,          32'd81,         1'b0};
        tbl[1]  = '{32'd0,          32'd0,          1'b0};
        tbl[2]  = '{32'd1,          32'd1,          1'b0};
        tbl[3]  = '{32'd2,          32'd16,         1'b0};
        tbl[4]  = '{32'd25,         32'd390625,     1'b0};
        tbl[5]  = '{32'd256,        32'd0,          1'b1};
        tbl[6]  = '{32'd255,        32'd4228250625, 1'b0};
        tbl[7]  = '{32'd65536,      32'd0,          1'b1};
        tbl[8]  = '{32'd7,          32'd2401,       1'b0};
        tbl[9]  = '{32'hFFFF_FFFF,  32'd1,          1'b1};
        tbl[10] = '{32'd10,         32'd10000,      1'b0};
        tbl[11] = '{32'd16,         32'd65536,      1'b0};
        tbl[12] = '{32'd17,         32'd83521,      1'b0};

        // Reset state
        do_reset();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_y", 64'(y), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid1", 64'(out_valid1), 64'd0);
        chk("rst_y1", 64'(y1), 64'd0);
`ifdef POW_PIPE_OVF_EN
        chk("rst_ovf", 64'(out_ovf), 64'd0);
`endif

        // Streaming table: one operand per cycle, result EXP cycles later
        for (int i = 0; i < N + EXP; i++) begin
            if (i > 0) @(negedge clk);
            if (i >= EXP) begin
                chk("stream_valid", 64'(out_valid), 64'd1);
                chk($sformatf("stream_y[%0d]", i - EXP), 64'(y),
                    64'(tbl[i-EXP].y));
`ifdef POW_PIPE_OVF_EN
                chk($sformatf("stream_ovf[%0d]", i - EXP), 64'(out_ovf),
                    64'(tbl[i-EXP].ovf));
`endif
            end else begin
                chk("stream_lat_valid", 64'(out_valid), 64'd0);
            end
            chk("stream_in_ready", 64'(in_ready), 64'd1);
            if (i < N) begin
                in_valid = 1'b1;
                a        = tbl[i].a;
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk("stream_drain_valid", 64'(out_valid), 64'd0);

        // Backpressure: 2,3,4 with consumer stalled
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a        = 32'(i + 2);
            @(negedge clk);
        end
        in_valid = 1'b0;
        begin
            int w;
            w = 0;
            while (!out_valid && w < 10) begin
                @(negedge clk);
                w++;
            end
            chk("bp_wait_valid", 64'(out_valid), 64'd1);
        end
        for (int i = 0; i < 3; i++) begin
            chk("bp_hold_valid", 64'(out_valid), 64'd1);
            chk("bp_hold_y", 64'(y), 64'd16);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            if (i < 2) @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_rel_valid0", 64'(out_valid), 64'd1);
        chk("bp_rel_y0", 64'(y), 64'd81);
        @(negedge clk);
        chk("bp_rel_valid1", 64'(out_valid), 64'd1);
        chk("bp_rel_y1", 64'(y), 64'd256);
        @(negedge clk);
        chk("bp_rel_empty", 64'(out_valid), 64'd0);

        // Reset mid-flight discards 2,3,4
        do_reset();
        in_valid = 1'b1;
        a        = 32'd2;
        @(negedge clk);
        a = 32'd3;
        @(negedge clk);
        a   = 32'd4;
        rst = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("mid_rst_valid", 64'(out_valid), 64'd0);
        end
        in_valid = 1'b1;
        a        = 32'd5;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 1; i < EXP; i++) begin
            chk("post_rst_lat", 64'(out_valid), 64'd0);
            @(negedge clk);
        end
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        chk("post_rst_y", 64'(y), 64'd625);

        // EXP=1, OUT_WIDTH=8 instance
        in_valid1 = 1'b1;
        a1        = 32'd300;
        @(negedge clk);
        in_valid1 = 1'b0;
        chk("e1_valid", 64'(out_valid1), 64'd1);
        chk("e1_y", 64'(y1), 64'd44);
`ifdef POW_PIPE_OVF_EN
        chk("e1_ovf", 64'(out_ovf1), 64'd1);
`endif
        @(negedge clk);
        chk("e1_empty", 64'(out_valid1), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
